// File: rtl/active_pixel_pingpong_buf_if.sv
// rtl/active_pixel_pingpong_buf_if.sv - writer/reader bus of the ping-pong active-pixel buffer
interface active_pixel_pingpong_buf_if #(
    parameter int DATA_W = 1,
    parameter int ADDR_W = 11
);
    logic              wen_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              wcommit_i;
    logic              wready_o;
    logic              ren_i;
    logic [ADDR_W-1:0] raddr_i;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_valid_o;
    logic              ravail_o;
    logic              rrelease_i;
    logic              wbank_o;
    logic              rbank_o;
    logic              overflow_o;
    logic              underflow_o;
    logic              clear_i;

    modport master (
        output wen_i, waddr_i, wdata_i, wcommit_i,
        output ren_i, raddr_i, rrelease_i, clear_i,
        input  wready_o, rdata_o, rdata_valid_o, ravail_o,
        input  wbank_o, rbank_o, overflow_o, underflow_o
    );

    modport slave (
        input  wen_i, waddr_i, wdata_i, wcommit_i,
        input  ren_i, raddr_i, rrelease_i, clear_i,
        output wready_o, rdata_o, rdata_valid_o, ravail_o,
        output wbank_o, rbank_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/active_pixel_pingpong_buf.sv
// rtl/active_pixel_pingpong_buf.sv - double-buffered active-pixel store with commit/release bank handover
module active_pixel_pingpong_buf #(
    parameter int DATA_W = 1,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    active_pixel_pingpong_buf_if.slave bus
);
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [1:0]        full_q, full_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wready;
    logic              ravail;
    logic              waddr_ok;
    logic              raddr_ok;
    logic              wr_fire;
    logic [IDX_W-1:0]  widx;
    logic [IDX_W-1:0]  ridx;

    assign wready   = ~full_q[wsel_q];
    assign ravail   = full_q[rsel_q];
    assign waddr_ok = {1'b0, bus.waddr_i} < DEPTH_C;
    assign raddr_ok = {1'b0, bus.raddr_i} < DEPTH_C;
    assign widx     = bus.waddr_i[IDX_W-1:0];
    assign ridx     = bus.raddr_i[IDX_W-1:0];
    assign wr_fire  = ~rst_i & ~bus.clear_i & bus.wen_i & wready & waddr_ok;

    // RAM array kept free of reset so it maps onto block RAM; flushing only drops ownership
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wsel_q][widx] <= bus.wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            full_q   <= 2'b00;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            full_q   <= full_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_comb begin
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
        full_d   = full_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus.clear_i) begin
            wsel_d  = 1'b0;
            rsel_d  = 1'b0;
            full_d  = 2'b00;
            rdata_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (bus.wen_i && !wready) begin
                ovf_d = 1'b1;
            end
            // commit and release never target the same bank: one needs full=0, the other full=1
            if (bus.wcommit_i) begin
                if (wready) begin
                    full_d[wsel_q] = 1'b1;
                    wsel_d         = ~wsel_q;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (bus.rrelease_i) begin
                if (ravail) begin
                    full_d[rsel_q] = 1'b0;
                    rsel_d         = ~rsel_q;
                end else begin
                    udf_d = 1'b1;
                end
            end
            if (bus.ren_i) begin
                if (ravail) begin
                    rvalid_d = 1'b1;
                    rdata_d  = raddr_ok ? mem_q[rsel_q][ridx] : '0;
                end else begin
                    rdata_d = '0;
                    udf_d   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.wready_o      = wready;
        bus.ravail_o      = ravail;
        bus.wbank_o       = wsel_q;
        bus.rbank_o       = rsel_q;
        bus.rdata_o       = rdata_q;
        bus.rdata_valid_o = rvalid_q;
        bus.overflow_o    = ovf_q;
        bus.underflow_o   = udf_q;
    end
endmodule
